// File: rtl/stack_game_ctrl_if.sv
// rtl/stack_game_ctrl_if.sv - Control inputs and render outputs of the stack game logic stage.
interface stack_game_ctrl_if;
   logic        tick;
   logic        start;
   logic        btn_left;
   logic        btn_right;
   logic [9:0]  pos_x;
   logic [31:0] colors;
   logic [9:0]  fall_x;
   logic [9:0]  fall_y;
   logic [1:0]  fall_clr;
   logic [3:0]  height;
   logic [1:0]  misses;
   logic        game_over;
   logic        win;

   modport master (
      output tick, start, btn_left, btn_right,
      input  pos_x, colors, fall_x, fall_y, fall_clr, height, misses, game_over, win
   );

   modport slave (
      input  tick, start, btn_left, btn_right,
      output pos_x, colors, fall_x, fall_y, fall_clr, height, misses, game_over, win
   );
endinterface

// File: rtl/stack_game_ctrl.sv
// rtl/stack_game_ctrl.sv - Stack game logic: tray motion, falling block spawn, catch/miss and colour stack.
// Optional macro SPEEDUP_EN: fall step grows by one per four stacked blocks.
module stack_game_ctrl #(
   parameter int SCREEN_W     = 640,
   parameter int SCREEN_H     = 480,
   parameter int TRAY_W       = 100,
   parameter int BASE_Y       = 400,
   parameter int HEIGHT_RATIO = 20,
   parameter int BLOCK_W      = 20,
   parameter int BLOCK_H      = 20,
   parameter int TRAY_STEP    = 8,
   parameter int FALL_STEP    = 4,
   parameter int MAX_MISS     = 3
) (
   input  logic clk,
   input  logic rst_n,
   stack_game_ctrl_if.slave bus
);

   localparam logic [9:0]  POS_INIT   = 10'((SCREEN_W - TRAY_W) / 2);
   localparam logic [10:0] POS_MAX    = 11'(SCREEN_W - TRAY_W);
   localparam logic [10:0] X_MAX      = 11'(SCREEN_W - BLOCK_W);
   localparam logic [10:0] T_STEP     = 11'(TRAY_STEP);
   localparam logic [1:0]  MISS_LIMIT = 2'(MAX_MISS);

   typedef enum logic [2:0] {S_IDLE, S_SPAWN, S_FALL, S_OVER, S_WIN} state_t;

   state_t      state_q;
   logic [15:0] lfsr_q;
   logic [9:0]  pos_x_q;
   logic [31:0] colors_q;
   logic [9:0]  fall_x_q;
   logic [9:0]  fall_y_q;
   logic [1:0]  fall_clr_q;
   logic [3:0]  height_q;
   logic [1:0]  misses_q;
   logic        game_over_q;
   logic        win_q;

   logic [15:0] lfsr_d;
   logic [9:0]  spawn_x_d;
   logic [1:0]  spawn_clr_d;
   logic [10:0] step_d;
   logic [10:0] ny_d;
   logic [10:0] top_d;
   logic [10:0] tray_d;
   logic [4:0]  slot_d;
   logic        overlap_d;
   logic        catch_d;
   logic        miss_d;

   // All tick decisions use the pre-update registers, widened to 11 bits.
   always_comb begin
      lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      spawn_x_d   = ({1'b0, lfsr_q[9:0]} <= X_MAX) ? lfsr_q[9:0] : {1'b0, lfsr_q[8:0]};
      spawn_clr_d = (lfsr_q[11:10] == 2'b00) ? 2'b10 : lfsr_q[11:10];
`ifdef SPEEDUP_EN
      step_d      = 11'(FALL_STEP) + {9'd0, height_q[3:2]};
`else
      step_d      = 11'(FALL_STEP);
`endif
      ny_d        = {1'b0, fall_y_q} + step_d;
      top_d       = 11'(BASE_Y) - 11'(height_q) * 11'(HEIGHT_RATIO);
      overlap_d   = (({1'b0, fall_x_q} + 11'(BLOCK_W)) > {1'b0, pos_x_q}) &&
                    ({1'b0, fall_x_q} < ({1'b0, pos_x_q} + 11'(TRAY_W)));
      catch_d     = ((ny_d + 11'(BLOCK_H)) >= top_d) && overlap_d;
      miss_d      = ny_d >= 11'(SCREEN_H);
      slot_d      = {1'b0, height_q} + 5'd1;

      tray_d = {1'b0, pos_x_q};
      if (bus.btn_left && !bus.btn_right) begin
         tray_d = ({1'b0, pos_x_q} < T_STEP) ? 11'd0 : {1'b0, pos_x_q} - T_STEP;
      end else if (bus.btn_right && !bus.btn_left) begin
         tray_d = (({1'b0, pos_x_q} + T_STEP) > POS_MAX) ? POS_MAX : {1'b0, pos_x_q} + T_STEP;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         lfsr_q      <= 16'hACE1;
         pos_x_q     <= POS_INIT;
         colors_q    <= 32'd0;
         fall_x_q    <= 10'd0;
         fall_y_q    <= 10'd0;
         fall_clr_q  <= 2'b00;
         height_q    <= 4'd0;
         misses_q    <= 2'd0;
         game_over_q <= 1'b0;
         win_q       <= 1'b0;
      end else begin
         // Free-running so spawn positions depend on when the player starts.
         lfsr_q <= lfsr_d;
         case (state_q)
            S_IDLE, S_OVER, S_WIN: begin
               if (bus.start) begin
                  colors_q    <= 32'd0;
                  height_q    <= 4'd0;
                  misses_q    <= 2'd0;
                  pos_x_q     <= POS_INIT;
                  game_over_q <= 1'b0;
                  win_q       <= 1'b0;
                  state_q     <= S_SPAWN;
               end
            end
            S_SPAWN: begin
               fall_y_q   <= 10'd0;
               fall_x_q   <= spawn_x_d;
               fall_clr_q <= spawn_clr_d;
               state_q    <= S_FALL;
            end
            S_FALL: begin
               if (bus.tick) begin
                  pos_x_q <= tray_d[9:0];
                  if (catch_d) begin
                     colors_q   <= colors_q | ({30'd0, fall_clr_q} << {slot_d, 1'b0});
                     height_q   <= height_q + 4'd1;
                     fall_clr_q <= 2'b00;
                     if (height_q == 4'd14) begin
                        win_q   <= 1'b1;
                        state_q <= S_WIN;
                     end else begin
                        state_q <= S_SPAWN;
                     end
                  end else if (miss_d) begin
                     misses_q   <= misses_q + 2'd1;
                     fall_clr_q <= 2'b00;
                     if ((misses_q + 2'd1) == MISS_LIMIT) begin
                        game_over_q <= 1'b1;
                        state_q     <= S_OVER;
                     end else begin
                        state_q <= S_SPAWN;
                     end
                  end else begin
                     fall_y_q <= ny_d[9:0];
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.pos_x     = pos_x_q;
   assign bus.colors    = colors_q;
   assign bus.fall_x    = fall_x_q;
   assign bus.fall_y    = fall_y_q;
   assign bus.fall_clr  = fall_clr_q;
   assign bus.height    = height_q;
   assign bus.misses    = misses_q;
   assign bus.game_over = game_over_q;
   assign bus.win       = win_q;

endmodule

// File: tb/tb_stack_game_ctrl.sv
// tb/tb_stack_game_ctrl.sv - Directed self-checking bench for stack_game_ctrl.
module tb_stack_game_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   stack_game_ctrl_if bus();
   stack_game_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_pass = 0;
   int n_total = 0;

   // Reference LFSR: lfsr_p holds the value seen by the most recent clock edge.
   logic [15:0] lfsr_m, lfsr_p;
   int          h_m, fy_m;
   logic [31:0] exp_colors;
   logic [1:0]  cur_clr;
   logic [9:0]  cur_fx;

   function automatic logic [15:0] lfsr_nx(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   function automatic logic [9:0] fx_of(input logic [15:0] l);
      if (l[9:0] <= 10'd620) return l[9:0];
      return {1'b0, l[8:0]};
   endfunction

   function automatic logic [1:0] clr_of(input logic [15:0] l);
      return (l[11:10] == 2'b00) ? 2'b10 : l[11:10];
   endfunction

   function automatic int step_of(input int h);
`ifdef SPEEDUP_EN
      return 4 + (h / 4);
`else
      return 4 + 0 * h;
`endif
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_m <= 16'hACE1;
         lfsr_p <= 16'hACE1;
      end else begin
         lfsr_p <= lfsr_m;
         lfsr_m <= lfsr_nx(lfsr_m);
      end
   end

   task automatic tick_only();
      bus.tick = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
   endtask

   task automatic do_tick();
      tick_only();
      @(negedge clk);
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      cur_fx  = fx_of(lfsr_p);
      cur_clr = clr_of(lfsr_p);
      fy_m    = 0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Idle until the block spawned after the next edge pair lands in [lo,hi].
   task automatic wait_for_fx(input int lo, input int hi, output bit ok);
      int i;
      logic [9:0] p;
      ok = 1'b0;
      i = 0;
      while (!ok && i < 4000) begin
         p = fx_of(lfsr_nx(lfsr_m));
         if (int'(p) >= lo && int'(p) <= hi) ok = 1'b1;
         else @(negedge clk);
         i++;
      end
   endtask

   // Tick until the next tick catches, then time it so the next spawn sits over the tray.
   task automatic advance_to_catch(output bit ok);
      int s;
      s = step_of(h_m);
      while (fy_m + s + 20 < 400 - 20 * h_m) begin
         do_tick();
         fy_m += s;
      end
      wait_for_fx(260, 360, ok);
   endtask

   task automatic finish_catch();
      exp_colors[2*(h_m+1) +: 2] = cur_clr;
      h_m++;
      @(negedge clk);
      cur_fx  = fx_of(lfsr_p);
      cur_clr = clr_of(lfsr_p);
      fy_m    = 0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_total++; if (bus.pos_x !== 10'd270) $display("FAIL reset_pos_x: got %0d want 270", bus.pos_x); else n_pass++;
      n_total++; if (bus.colors !== 32'd0) $display("FAIL reset_colors: got %h want 0", bus.colors); else n_pass++;
      n_total++; if (bus.fall_x !== 10'd0) $display("FAIL reset_fall_x: got %0d want 0", bus.fall_x); else n_pass++;
      n_total++; if (bus.fall_y !== 10'd0) $display("FAIL reset_fall_y: got %0d want 0", bus.fall_y); else n_pass++;
      n_total++; if (bus.fall_clr !== 2'b00) $display("FAIL reset_fall_clr: got %b want 00", bus.fall_clr); else n_pass++;
      n_total++; if (bus.height !== 4'd0) $display("FAIL reset_height: got %0d want 0", bus.height); else n_pass++;
      n_total++; if (bus.misses !== 2'd0) $display("FAIL reset_misses: got %0d want 0", bus.misses); else n_pass++;
      n_total++; if (bus.game_over !== 1'b0) $display("FAIL reset_game_over: got %b want 0", bus.game_over); else n_pass++;
      n_total++; if (bus.win !== 1'b0) $display("FAIL reset_win: got %b want 0", bus.win); else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_tray();
      pulse_start();
      n_total++; if (bus.fall_x !== cur_fx) $display("FAIL spawn_fall_x: got %0d want %0d", bus.fall_x, cur_fx); else n_pass++;
      n_total++; if (bus.fall_clr !== cur_clr) $display("FAIL spawn_fall_clr: got %b want %b", bus.fall_clr, cur_clr); else n_pass++;
      n_total++; if (bus.fall_y !== 10'd0) $display("FAIL spawn_fall_y: got %0d want 0", bus.fall_y); else n_pass++;
      repeat (3) @(negedge clk);
      n_total++; if (bus.fall_y !== 10'd0) $display("FAIL no_tick_hold: got %0d want 0", bus.fall_y); else n_pass++;
      bus.btn_right = 1'b1;
      repeat (33) do_tick();
      n_total++; if (bus.pos_x !== 10'd534) $display("FAIL tray_right_33: got %0d want 534", bus.pos_x); else n_pass++;
      repeat (7) do_tick();
      n_total++; if (bus.pos_x !== 10'd540) $display("FAIL tray_clamp_right: got %0d want 540", bus.pos_x); else n_pass++;
      n_total++; if (bus.fall_y !== 10'd160) $display("FAIL fall_40_ticks: got %0d want 160", bus.fall_y); else n_pass++;
      bus.btn_left = 1'b1;
      repeat (2) do_tick();
      n_total++; if (bus.pos_x !== 10'd540) $display("FAIL tray_both_hold: got %0d want 540", bus.pos_x); else n_pass++;
      bus.btn_right = 1'b0;
      do_tick();
      n_total++; if (bus.pos_x !== 10'd532) $display("FAIL tray_left: got %0d want 532", bus.pos_x); else n_pass++;
      bus.btn_left = 1'b0;
   endtask

   task automatic test_reset_midgame();
      #2 rst_n = 1'b0;
      #1;
      n_total++; if (bus.pos_x !== 10'd270) $display("FAIL async_pos_x: got %0d want 270", bus.pos_x); else n_pass++;
      n_total++; if (bus.fall_y !== 10'd0) $display("FAIL async_fall_y: got %0d want 0", bus.fall_y); else n_pass++;
      n_total++; if (bus.fall_clr !== 2'b00) $display("FAIL async_fall_clr: got %b want 00", bus.fall_clr); else n_pass++;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      bus.btn_right = 1'b1;
      repeat (3) do_tick();
      bus.btn_right = 1'b0;
      n_total++; if (bus.pos_x !== 10'd270) $display("FAIL idle_tray_frozen: got %0d want 270", bus.pos_x); else n_pass++;
      n_total++; if (bus.fall_y !== 10'd0) $display("FAIL idle_no_fall: got %0d want 0", bus.fall_y); else n_pass++;
   endtask

   task automatic test_catch();
      bit ok;
      wait_for_fx(260, 360, ok);
      n_total++; if (!ok) $display("FAIL catch_setup_timeout: got 0 want 1"); else n_pass++;
      pulse_start();
      h_m = 0;
      exp_colors = 32'd0;
      repeat (90) do_tick();
      fy_m = 360;
      n_total++; if (bus.fall_y !== 10'd360) $display("FAIL fall_90_ticks: got %0d want 360", bus.fall_y); else n_pass++;
      advance_to_catch(ok);
      n_total++; if (bus.fall_y !== 10'd376) $display("FAIL pre_catch_y: got %0d want 376", bus.fall_y); else n_pass++;
      tick_only();
      n_total++; if (bus.height !== 4'd1) $display("FAIL catch_height: got %0d want 1", bus.height); else n_pass++;
      n_total++; if (bus.colors !== {28'd0, cur_clr, 2'b00}) $display("FAIL catch_colors: got %h want %h", bus.colors, {28'd0, cur_clr, 2'b00}); else n_pass++;
      n_total++; if (bus.fall_clr !== 2'b00) $display("FAIL catch_fall_clr: got %b want 00", bus.fall_clr); else n_pass++;
      finish_catch();
      n_total++; if (bus.fall_y !== 10'd0) $display("FAIL respawn_fall_y: got %0d want 0", bus.fall_y); else n_pass++;
      n_total++; if (bus.fall_x !== cur_fx) $display("FAIL respawn_fall_x: got %0d want %0d", bus.fall_x, cur_fx); else n_pass++;
      n_total++; if (bus.fall_clr !== cur_clr) $display("FAIL respawn_fall_clr: got %b want %b", bus.fall_clr, cur_clr); else n_pass++;
   endtask

   task automatic test_miss();
      bit ok;
      bit go_left;
      apply_reset();
      wait_for_fx(380, 620, ok);
      n_total++; if (!ok) $display("FAIL miss_setup_timeout: got 0 want 1"); else n_pass++;
      pulse_start();
      repeat (119) do_tick();
      n_total++; if (bus.fall_y !== 10'd476) $display("FAIL fall_119_ticks: got %0d want 476", bus.fall_y); else n_pass++;
      n_total++; if (bus.misses !== 2'd0) $display("FAIL pre_miss: got %0d want 0", bus.misses); else n_pass++;
      tick_only();
      n_total++; if (bus.misses !== 2'd1) $display("FAIL miss_one: got %0d want 1", bus.misses); else n_pass++;
      n_total++; if (bus.fall_clr !== 2'b00) $display("FAIL miss_fall_clr: got %b want 00", bus.fall_clr); else n_pass++;
      go_left = 1'b0;
      for (int k = 2; k <= 3; k++) begin
         @(negedge clk);
         go_left = (fx_of(lfsr_p) >= 10'd120);
         bus.btn_left  = go_left;
         bus.btn_right = !go_left;
         repeat (119) do_tick();
         tick_only();
         n_total++; if (int'(bus.misses) != k) $display("FAIL miss_count_%0d: got %0d want %0d", k, bus.misses, k); else n_pass++;
      end
      n_total++; if (bus.game_over !== 1'b1) $display("FAIL game_over: got %b want 1", bus.game_over); else n_pass++;
      n_total++; if (bus.fall_clr !== 2'b00) $display("FAIL over_fall_clr: got %b want 00", bus.fall_clr); else n_pass++;
      repeat (5) do_tick();
      n_total++; if (bus.pos_x !== (go_left ? 10'd0 : 10'd540)) $display("FAIL over_tray_frozen: got %0d want %0d", bus.pos_x, go_left ? 0 : 540); else n_pass++;
      n_total++; if (bus.fall_y !== 10'd476) $display("FAIL over_fall_frozen: got %0d want 476", bus.fall_y); else n_pass++;
      n_total++; if (bus.misses !== 2'd3) $display("FAIL over_misses_hold: got %0d want 3", bus.misses); else n_pass++;
      bus.btn_left  = 1'b0;
      bus.btn_right = 1'b0;
   endtask

   task automatic test_speedup();
      bit ok;
      int exp_step;
      apply_reset();
      wait_for_fx(260, 360, ok);
      pulse_start();
      h_m = 0;
      exp_colors = 32'd0;
      for (int c = 0; c < 4; c++) begin
         advance_to_catch(ok);
         n_total++; if (!ok) $display("FAIL speedup_catch_timeout_%0d: got 0 want 1", c); else n_pass++;
         tick_only();
         finish_catch();
      end
      n_total++; if (bus.height !== 4'd4) $display("FAIL speedup_height: got %0d want 4", bus.height); else n_pass++;
`ifdef SPEEDUP_EN
      exp_step = 5;
`else
      exp_step = 4;
`endif
      do_tick();
      fy_m = exp_step;
      n_total++; if (int'(bus.fall_y) != exp_step) $display("FAIL speedup_step: got %0d want %0d", bus.fall_y, exp_step); else n_pass++;
   endtask

   task automatic test_win();
      bit ok;
      while (h_m < 15) begin
         advance_to_catch(ok);
         n_total++; if (!ok) $display("FAIL win_catch_timeout_%0d: got 0 want 1", h_m); else n_pass++;
         tick_only();
         if (h_m == 14) begin
            n_total++; if (bus.height !== 4'd15) $display("FAIL win_height: got %0d want 15", bus.height); else n_pass++;
            n_total++; if (bus.win !== 1'b1) $display("FAIL win_flag: got %b want 1", bus.win); else n_pass++;
            n_total++; if (bus.fall_clr !== 2'b00) $display("FAIL win_fall_clr: got %b want 00", bus.fall_clr); else n_pass++;
         end else if (h_m == 13) begin
            n_total++; if (bus.win !== 1'b0) $display("FAIL win_early: got %b want 0", bus.win); else n_pass++;
         end
         finish_catch();
      end
      n_total++; if (bus.colors !== exp_colors) $display("FAIL win_colors: got %h want %h", bus.colors, exp_colors); else n_pass++;
      for (int s = 1; s < 16; s++) begin
         n_total++; if (bus.colors[2*s +: 2] === 2'b00) $display("FAIL win_slot_%0d: got 00 want nonzero", s); else n_pass++;
      end
      repeat (3) do_tick();
      n_total++; if (bus.height !== 4'd15) $display("FAIL win_hold_height: got %0d want 15", bus.height); else n_pass++;
      pulse_start();
      n_total++; if (bus.colors !== 32'd0) $display("FAIL restart_colors: got %h want 0", bus.colors); else n_pass++;
      n_total++; if (bus.height !== 4'd0) $display("FAIL restart_height: got %0d want 0", bus.height); else n_pass++;
      n_total++; if (bus.win !== 1'b0) $display("FAIL restart_win: got %b want 0", bus.win); else n_pass++;
      n_total++; if (bus.pos_x !== 10'd270) $display("FAIL restart_pos_x: got %0d want 270", bus.pos_x); else n_pass++;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      bus.tick = 1'b0;
      bus.start = 1'b0;
      bus.btn_left = 1'b0;
      bus.btn_right = 1'b0;
      h_m = 0;
      fy_m = 0;
      exp_colors = 32'd0;
      cur_clr = 2'b00;
      cur_fx = 10'd0;
      test_reset();
      test_tray();
      test_reset_midgame();
      test_catch();
      test_miss();
      test_speedup();
      test_win();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
